// File: rtl/ex_muldiv_if.sv
// Handshake/bus bundle between the ID/EX pipeline register and the EX-stage
// multiply/divide unit, including the architectural HI/LO outputs.
interface ex_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             op_valid;
    logic [2:0]       op;
    logic             flush;
    logic             hilo_read;
    logic [WIDTH-1:0] DataA;
    logic [WIDTH-1:0] DataB;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             stall;
    logic             done;

    modport master (
        output op_valid, op, flush, hilo_read, DataA, DataB,
        input  hi, lo, busy, stall, done
    );

    modport slave (
        input  op_valid, op, flush, hilo_read, DataA, DataB,
        output hi, lo, busy, stall, done
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit: 32-step shift-add multiply,
// restoring divide, HI/LO registers and pipeline stall generation.
//
// state | meaning
// IDLE  | waiting; accepts muldiv ops, MTHI/MTLO write HI/LO directly
// MUL   | one shift-add multiply iteration per cycle (count 0..WIDTH-1)
// DIV   | one restoring divide iteration per cycle (count 0..WIDTH-1)
// FIX   | sign correction, HI/LO write, done pulse
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic         clock,
    input logic         reset,
    ex_muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [CW-1:0]      count;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               busy_q;
    logic               done_q;

    logic               legal;
    logic               accept;
    logic               signed_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH+1:0]   div_trial;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign legal     = (bus.op <= OP_MTLO);
    assign accept    = (state == IDLE) && bus.op_valid && !bus.flush && legal;
    assign signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign a_neg     = signed_op && bus.DataA[WIDTH-1];
    assign b_neg     = signed_op && bus.DataB[WIDTH-1];
    assign a_abs     = a_neg ? -bus.DataA : bus.DataA;
    assign b_abs     = b_neg ? -bus.DataB : bus.DataB;

    // The accumulator is shared: {upper, multiplier} for MUL, {rem, quot} for DIV.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        mul_next  = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
        div_sh    = acc[2*WIDTH-1:WIDTH-1];
        div_trial = {1'b0, div_sh} - {2'b00, opnd};
        div_next  = div_trial[WIDTH+1] ? {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                       : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        prod_fix  = neg_q ? -acc : acc;
        quot_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix   = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            acc    <= '0;
            opnd   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            count  <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (bus.op)
                            OP_MTHI: hi_q <= bus.DataA;
                            OP_MTLO: lo_q <= bus.DataA;
                            OP_MULT, OP_MULTU: begin
                                acc    <= {{WIDTH{1'b0}}, b_abs};
                                opnd   <= a_abs;
                                neg_q  <= a_neg ^ b_neg;
                                neg_r  <= 1'b0;
                                is_div <= 1'b0;
                                count  <= '0;
                                busy_q <= 1'b1;
                                state  <= MUL;
                            end
                            default: begin
                                is_div <= 1'b1;
                                busy_q <= 1'b1;
                                count  <= '0;
                                if (bus.DataB == '0) begin
                                    // Divide by zero skips iterations: HI = raw dividend, LO = all-ones.
                                    acc   <= {bus.DataA, {WIDTH{1'b1}}};
                                    neg_q <= 1'b0;
                                    neg_r <= 1'b0;
                                    state <= FIX;
                                end else begin
                                    acc   <= {{WIDTH{1'b0}}, a_abs};
                                    opnd  <= b_abs;
                                    neg_q <= a_neg ^ b_neg;
                                    neg_r <= a_neg;
                                    state <= DIV;
                                end
                            end
                        endcase
                    end
                end
                MUL: begin
                    acc   <= mul_next;
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH-1)) state <= FIX;
                end
                DIV: begin
                    acc   <= div_next;
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH-1)) state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        hi_q <= rem_fix;
                        lo_q <= quot_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                    count  <= '0;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.stall = busy_q && ((bus.op_valid && !bus.flush) || bus.hilo_read);
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed scenarios plus randomized
// traffic, compared each cycle against an arithmetic reference model.
module tb_ex_muldiv_unit;
    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    ex_muldiv_if #(.WIDTH(32)) bus ();

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int          m_rem = 0;
    logic        m_done = 1'b0;

    // values observed at the last sample point
    logic [31:0] obs_hi, obs_lo;
    logic        obs_busy, obs_done, obs_stall;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected HI/LO from plain arithmetic, and cycles from accept to HI/LO write.
    task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] rhi, output logic [31:0] rlo, output int cyc);
        longint      sa, sb, q, r;
        logic [63:0] p, qq, rr;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        cyc = 33;
        case (o)
            3'b000: p = 64'(sa * sb);
            3'b001: p = {32'b0, a} * {32'b0, b};
            default: p = '0;
        endcase
        rhi = p[63:32];
        rlo = p[31:0];
        if (o == 3'b010 || o == 3'b011) begin
            if (b == 0) begin
                rlo = '1;
                rhi = a;
                cyc = 1;
            end else begin
                if (o == 3'b010) begin
                    q = sa / sb;
                    r = sa % sb;
                end else begin
                    q = longint'({32'b0, a}) / longint'({32'b0, b});
                    r = longint'({32'b0, a}) % longint'({32'b0, b});
                end
                qq  = 64'(q);
                rr  = 64'(r);
                rlo = qq[31:0];
                rhi = rr[31:0];
            end
        end
    endtask

    task automatic step(input logic rst, input logic v, input logic [2:0] o, input logic fl,
                        input logic rd, input logic [31:0] a, input logic [31:0] b);
        int c;
        @(negedge clock);
        reset         = rst;
        bus.op_valid  = v;
        bus.op        = o;
        bus.flush     = fl;
        bus.hilo_read = rd;
        bus.DataA     = a;
        bus.DataB     = b;
        #1;
        obs_hi    = bus.hi;
        obs_lo    = bus.lo;
        obs_busy  = bus.busy;
        obs_done  = bus.done;
        obs_stall = bus.stall;
        chk("hi", 64'(obs_hi), 64'(m_hi));
        chk("lo", 64'(obs_lo), 64'(m_lo));
        chk("busy", 64'(obs_busy), 64'(m_rem > 0));
        chk("done", 64'(obs_done), 64'(m_done));
        chk("stall", 64'(obs_stall), 64'((m_rem > 0) && ((v && !fl) || rd)));
        @(posedge clock);
        m_done = 1'b0;
        if (rst) begin
            m_hi  = '0;
            m_lo  = '0;
            m_rem = 0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                m_hi   = p_hi;
                m_lo   = p_lo;
                m_done = 1'b1;
            end
        end else if (v && !fl && o <= 3'd5) begin
            if (o == 3'd4) m_hi = a;
            else if (o == 3'd5) m_lo = a;
            else begin
                model_op(o, a, b, p_hi, p_lo, c);
                m_rem = c;
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, '0, '0);
    endtask

    // Issue one op, then idle until done; reports done latency and busy cycles.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int nbusy);
        lat   = -1;
        nbusy = 0;
        step(1'b0, 1'b1, o, 1'b0, 1'b0, a, b);
        for (int i = 1; i <= 40; i++) begin
            idle();
            if (obs_busy) nbusy++;
            if (obs_done) begin
                lat = i;
                break;
            end
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, nb, nstall;
        bus.op_valid  = 1'b0;
        bus.op        = '0;
        bus.flush     = 1'b0;
        bus.hilo_read = 1'b0;
        bus.DataA     = '0;
        bus.DataB     = '0;
        repeat (2) @(posedge clock);

        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, '0, '0);
        idle();
        chk("reset_hi", 64'(obs_hi), 64'h0);
        chk("reset_busy", 64'(obs_busy), 64'h0);

        // 1: MULTU max*max
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, nb);
        chk("t1_hi", 64'(obs_hi), 64'hFFFF_FFFE);
        chk("t1_lo", 64'(obs_lo), 64'h0000_0001);
        chk("t1_lat", 64'(lat), 64'd34);
        chk("t1_busy_cycles", 64'(nb), 64'd33);

        // 2: signed multiply and divide
        run_op(3'b000, -32'sd7, 32'd3, lat, nb);
        chk("t2_mult_hi", 64'(obs_hi), 64'hFFFF_FFFF);
        chk("t2_mult_lo", 64'(obs_lo), 64'hFFFF_FFEB);
        run_op(3'b010, -32'sd7, 32'd2, lat, nb);
        chk("t2_div_lo", 64'(obs_lo), 64'hFFFF_FFFD);
        chk("t2_div_hi", 64'(obs_hi), 64'hFFFF_FFFF);

        // 3: divide by zero and signed overflow
        run_op(3'b011, 32'd100, 32'd0, lat, nb);
        chk("t3_dz_lo", 64'(obs_lo), 64'hFFFF_FFFF);
        chk("t3_dz_hi", 64'(obs_hi), 64'd100);
        chk("t3_dz_lat", 64'(lat), 64'd2);
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, lat, nb);
        chk("t3_ovf_lo", 64'(obs_lo), 64'h8000_0000);
        chk("t3_ovf_hi", 64'(obs_hi), 64'h0);

        // 4: MFHI and a second MULT held in ID/EX while busy
        nstall = 0;
        step(1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 32'd5, -32'sd3);
        for (int i = 1; i <= 34; i++) begin
            step(1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 32'd1000, -32'sd1000);
            if (i <= 33 && obs_stall) nstall++;
            if (i == 34) begin
                chk("t4_stall_done", 64'(obs_stall), 64'h0);
                chk("t4_first_done", 64'(obs_done), 64'h1);
                chk("t4_first_lo", 64'(obs_lo), 64'hFFFF_FFF1);
            end
        end
        chk("t4_stall_cycles", 64'(nstall), 64'd33);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            idle();
            if (obs_done) begin
                lat = i;
                break;
            end
        end
        chk("t4_second_lat", 64'(lat), 64'd34);
        chk("t4_second_lo", 64'(obs_lo), 64'hFFF0_BDC0);
        chk("t4_second_hi", 64'(obs_hi), 64'hFFFF_FFFF);

        // 5: flushed MTLO is dropped, unflushed one lands in one edge
        step(1'b0, 1'b1, 3'b101, 1'b0, 1'b0, 32'hAAAA, '0);
        step(1'b0, 1'b1, 3'b101, 1'b1, 1'b0, 32'h1234, '0);
        idle();
        chk("t5_flushed_lo", 64'(obs_lo), 64'hAAAA);
        step(1'b0, 1'b1, 3'b101, 1'b0, 1'b0, 32'h1234, '0);
        idle();
        chk("t5_lo", 64'(obs_lo), 64'h1234);
        chk("t5_busy", 64'(obs_busy), 64'h0);

        // 6: reset in the middle of a DIVU
        step(1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 32'hFFFF_0000, 32'd7);
        for (int i = 1; i <= 10; i++) idle();
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, '0, '0);
        idle();
        chk("t6_hi", 64'(obs_hi), 64'h0);
        chk("t6_lo", 64'(obs_lo), 64'h0);
        chk("t6_busy", 64'(obs_busy), 64'h0);
        chk("t6_done", 64'(obs_done), 64'h0);
        run_op(3'b001, 32'd6, 32'd7, lat, nb);
        chk("t6_lo42", 64'(obs_lo), 64'd42);
        chk("t6_hi0", 64'(obs_hi), 64'h0);

        // randomized traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 599) == 0),
                 ($urandom_range(0, 2) == 0),
                 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) == 0),
                 pick(), pick());
        end
        repeat (40) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
